lock_code_sender: RTL and testbench
===================================

LOCK_CODE_SENDER -- requirements
Module: lock_code_sender

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 4, PRESS/ENTER low-pulse width in cycles (>=1).
REQ-002 SHALL have parameter GAP_CYC, default 4, high time after each PRESS pulse in cycles (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, maximum wait for lock response in cycles (>=1).
REQ-004 SHALL have parameter NDIGITS, default 4, digits per code word; KEY_WORD width = 4*NDIGITS.
REQ-005 Ports, clock and reset first: one clock; reset is asynchronous and active-high.
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request to send one code word; sampled in IDLE only.
- ABORT  in  1  cancel the current sequence.
- KEY_WORD  in  4*NDIGITS  digits to send, most-significant nibble first.
- MODE_REQ  in  1  mode level to present to the lock for the sequence.
- OPEN  in  1  lock response, high = accepted.
- ERROR  in  1  lock response, high = rejected.
- CODE  out  4  current digit.
- PRESS  out  1  digit strobe, active low.
- ENTER  out  1  submit strobe, active low.
- MODE  out  1  latched MODE_REQ.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle completion pulse.
- RESULT_OK / RESULT_ERR / TIMEOUT  out  1 each  sticky outcome flags.

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, PRESS_LO, GAP, ENTER_LO, WAIT_RESP and FINISH.
REQ-007 In IDLE, START=1 SHALL latch KEY_WORD and MODE_REQ, clear the outcome flags, set BUSY and enter SETUP on the next edge.
REQ-008 START while BUSY=1 SHALL be ignored, with no effect on state or latched data.
REQ-009 SETUP SHALL drive CODE with the current digit for exactly 1 cycle with PRESS=1 (setup time), then enter PRESS_LO.
REQ-010 PRESS_LO SHALL hold PRESS=0 for PULSE_CYC cycles; GAP SHALL hold PRESS=1 for GAP_CYC cycles; CODE SHALL be stable across SETUP, PRESS_LO and GAP.
REQ-011 After the GAP of digit index NDIGITS-1, the FSM SHALL enter ENTER_LO; otherwise it SHALL advance the digit index and return to SETUP.
REQ-012 ENTER_LO SHALL hold ENTER=0 for PULSE_CYC cycles, then enter WAIT_RESP.
REQ-013 WAIT_RESP SHALL resolve on the first cycle with ERROR=1 or OPEN=1:
- ERROR wins if both are high in the same cycle.
- No response within TIMEOUT_CYC cycles SHALL set TIMEOUT.
REQ-014 FINISH SHALL last 1 cycle with DONE=1, then the FSM SHALL return to IDLE with BUSY=0.
REQ-015 Outcome flags SHALL be mutually exclusive and SHALL hold until the next accepted START.
REQ-016 ABORT=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with PRESS=1, ENTER=1 and BUSY=0; DONE SHALL not pulse and the flags SHALL remain clear. ABORT SHALL take priority over all other transitions.
REQ-017 MODE SHALL equal the latched MODE_REQ from START until the next accepted START.
REQ-018 Minimum sequence length SHALL be NDIGITS*(1+PULSE_CYC+GAP_CYC) + PULSE_CYC + 1 (FINISH) cycles plus the response time.

Reset
REQ-019 RESET=1 SHALL asynchronously force state=IDLE, CODE=0, PRESS=1, ENTER=1, MODE=0, BUSY=0, DONE=0 and all outcome flags to 0.
REQ-020 RESET asserted mid-sequence SHALL abandon the sequence with no DONE pulse; operation resumes on the first edge after deassertion.

Configuration
REQ-021 With LOCK_SENDER_SYNC_EN defined, OPEN and ERROR SHALL pass through 2-flop synchronizers, adding 2 cycles of response latency (timeout count unchanged); without it they SHALL be sampled directly.

Structure
REQ-022 Package lock_pkg SHALL hold the FSM state enum and the default constants for PULSE_CYC, GAP_CYC and TIMEOUT_CYC.
REQ-023 Sub-module lock_cycle_timer SHALL be a loadable down-counter with a zero flag, shared by the pulse, gap and timeout phases.

Verification
REQ-024 KEY_WORD=16'h1234, START pulse, OPEN raised 5 cycles after ENTER rises -> CODE sequence 1,2,3,4; 4 PRESS pulses of 4 cycles; 1 ENTER pulse; RESULT_OK=1; DONE 1 cycle.
REQ-025 KEY_WORD=16'h9999, lock drives ERROR=1 and OPEN=1 in the same cycle -> RESULT_ERR=1, RESULT_OK=0.
REQ-026 No response from the lock -> TIMEOUT=1 exactly 64 cycles after entering WAIT_RESP, followed by DONE.
REQ-027 ABORT during the PRESS_LO of digit 2 -> PRESS=1 and BUSY=0 on the next cycle; no DONE; flags 0.
REQ-028 START reasserted while BUSY with KEY_WORD=16'hFFFF -> ignored; original digits sent unchanged.
REQ-029 RESET pulse during ENTER_LO -> ENTER=1 and all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and defaults for the lock code sender: FSM state encoding,
// default timing constants and a helper that sizes the shared phase timer.
package lock_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PRESS_LO,
        S_GAP,
        S_ENTER_LO,
        S_WAIT_RESP,
        S_FINISH
    } lock_state_e;

    localparam int PULSE_CYC_DEF   = 4;
    localparam int GAP_CYC_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    // Timer width able to hold (largest phase length - 1).
    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lock_code_sender_if.sv
// Lock-side and host-side signals of the code sender, bundled so the top
// takes a single interface port. master = host/lock model, slave = sender.
interface lock_code_sender_if #(
    parameter int NDIGITS = 4
) ();
    logic                   START;
    logic                   ABORT;
    logic [4*NDIGITS-1:0]   KEY_WORD;
    logic                   MODE_REQ;
    logic                   OPEN;
    logic                   ERROR;
    logic [3:0]             CODE;
    logic                   PRESS;
    logic                   ENTER;
    logic                   MODE;
    logic                   BUSY;
    logic                   DONE;
    logic                   RESULT_OK;
    logic                   RESULT_ERR;
    logic                   TIMEOUT;

    modport master (
        output START, ABORT, KEY_WORD, MODE_REQ, OPEN, ERROR,
        input  CODE, PRESS, ENTER, MODE, BUSY, DONE, RESULT_OK, RESULT_ERR, TIMEOUT
    );

    modport slave (
        input  START, ABORT, KEY_WORD, MODE_REQ, OPEN, ERROR,
        output CODE, PRESS, ENTER, MODE, BUSY, DONE, RESULT_OK, RESULT_ERR, TIMEOUT
    );
endinterface

// File: rtl/lock_cycle_timer.sv
// Loadable down-counter with a zero flag. One instance times the press
// pulse, the gap, the enter pulse and the response timeout in turn.
module lock_cycle_timer #(
    parameter int W = 6
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/lock_code_sender.sv
// Sends a multi-digit code to a keypad lock: each digit is presented on CODE,
// strobed with an active-low PRESS pulse, then ENTER is pulsed and the lock's
// OPEN/ERROR response is awaited with a timeout.
// Build option: define LOCK_SENDER_SYNC_EN to pass OPEN/ERROR through
// 2-flop synchronizers (adds 2 cycles of response latency).
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int PULSE_CYC   = PULSE_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int NDIGITS     = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    lock_code_sender_if.slave   bus
);
    localparam int KW = 4 * NDIGITS;
    localparam int TW = timer_w(PULSE_CYC, GAP_CYC, TIMEOUT_CYC);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    lock_state_e   state_q, state_d;
    logic [KW-1:0] key_q;
    logic [IW-1:0] idx_q;
    logic          mode_q;
    logic          ok_q, err_q, to_q;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic          latch_req, shift_key, clr_flags;
    logic          set_ok, set_err, set_to;
    logic          open_s, err_s;

`ifdef LOCK_SENDER_SYNC_EN
    logic [1:0] open_sync_q, err_sync_q;

    // Two-flop synchronizers for the asynchronous lock responses.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            open_sync_q <= '0;
            err_sync_q  <= '0;
        end else begin
            open_sync_q <= {open_sync_q[0], bus.OPEN};
            err_sync_q  <= {err_sync_q[0], bus.ERROR};
        end
    end

    assign open_s = open_sync_q[1];
    assign err_s  = err_sync_q[1];
`else
    assign open_s = bus.OPEN;
    assign err_s  = bus.ERROR;
`endif

    lock_cycle_timer #(.W(TW)) u_timer (
        .CLK        (CLK),
        .RESET      (RESET),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; each phase loads the timer with (length - 1) on entry.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        latch_req = 1'b0;
        shift_key = 1'b0;
        clr_flags = 1'b0;
        set_ok    = 1'b0;
        set_err   = 1'b0;
        set_to    = 1'b0;
        if (state_q != S_IDLE && bus.ABORT) begin
            state_d   = S_IDLE;
            clr_flags = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        state_d   = S_SETUP;
                        latch_req = 1'b1;
                        clr_flags = 1'b1;
                    end
                end
                S_SETUP: begin
                    state_d  = S_PRESS_LO;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PULSE_CYC - 1);
                end
                S_PRESS_LO: begin
                    if (tmr_zero) begin
                        state_d  = S_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(GAP_CYC - 1);
                    end
                end
                S_GAP: begin
                    if (tmr_zero) begin
                        if (idx_q == IW'(NDIGITS - 1)) begin
                            state_d  = S_ENTER_LO;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(PULSE_CYC - 1);
                        end else begin
                            state_d   = S_SETUP;
                            shift_key = 1'b1;
                        end
                    end
                end
                S_ENTER_LO: begin
                    if (tmr_zero) begin
                        state_d  = S_WAIT_RESP;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(TIMEOUT_CYC - 1);
                    end
                end
                S_WAIT_RESP: begin
                    // ERROR is checked first so a simultaneous OPEN loses.
                    if (err_s) begin
                        state_d = S_FINISH;
                        set_err = 1'b1;
                    end else if (open_s) begin
                        state_d = S_FINISH;
                        set_ok  = 1'b1;
                    end else if (tmr_zero) begin
                        state_d = S_FINISH;
                        set_to  = 1'b1;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Code word and mode capture; the key shifts so CODE is always its top nibble.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            key_q  <= '0;
            idx_q  <= '0;
            mode_q <= 1'b0;
        end else if (latch_req) begin
            key_q  <= bus.KEY_WORD;
            idx_q  <= '0;
            mode_q <= bus.MODE_REQ;
        end else if (shift_key) begin
            key_q  <= key_q << 4;
            idx_q  <= idx_q + 1'b1;
        end
    end

    // Sticky, mutually exclusive outcome flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
        end else if (clr_flags) begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            if (set_ok)  ok_q  <= 1'b1;
            if (set_err) err_q <= 1'b1;
            if (set_to)  to_q  <= 1'b1;
        end
    end

    assign bus.CODE       = key_q[KW-1 -: 4];
    assign bus.PRESS      = (state_q != S_PRESS_LO);
    assign bus.ENTER      = (state_q != S_ENTER_LO);
    assign bus.MODE       = mode_q;
    assign bus.BUSY       = (state_q != S_IDLE);
    assign bus.DONE       = (state_q == S_FINISH);
    assign bus.RESULT_OK  = ok_q;
    assign bus.RESULT_ERR = err_q;
    assign bus.TIMEOUT    = to_q;
endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: directed and randomized code sequences checked
// cycle by cycle against a timeline computed from the phase lengths.
module tb_lock_code_sender;
    localparam int N  = 4;
    localparam int P  = 4;
    localparam int G  = 4;
    localparam int T  = 64;
    localparam int L  = 1 + P + G;
    localparam int WS = N * L + P;

    logic CLK;
    logic RESET;
    int   n_pass;
    int   n_total;
    int   cur_t;

    lock_code_sender_if #(.NDIGITS(N)) bus ();

    lock_code_sender #(
        .PULSE_CYC   (P),
        .GAP_CYC     (G),
        .TIMEOUT_CYC (T),
        .NDIGITS     (N)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_code"},  32'(bus.CODE),       32'h0);
        chk({tag, "_press"}, 32'(bus.PRESS),      32'h1);
        chk({tag, "_enter"}, 32'(bus.ENTER),      32'h1);
        chk({tag, "_mode"},  32'(bus.MODE),       32'h0);
        chk({tag, "_busy"},  32'(bus.BUSY),       32'h0);
        chk({tag, "_done"},  32'(bus.DONE),       32'h0);
        chk({tag, "_ok"},    32'(bus.RESULT_OK),  32'h0);
        chk({tag, "_err"},   32'(bus.RESULT_ERR), 32'h0);
        chk({tag, "_to"},    32'(bus.TIMEOUT),    32'h0);
    endtask

    // kind: 0 no response, 1 OPEN, 2 ERROR, 3 both. resp_at: cycles after ENTER rises.
    task automatic run_seq(input logic [4*N-1:0] key, input logic mode, input int kind,
                           input int resp_at, input int abort_at, input bit junk);
        int  tr, fin, last, d;
        bit  e_ok, e_err, e_to;
        logic [3:0] e_code;
        bit  e_press, e_enter;

        bus.START    = 1'b1;
        bus.KEY_WORD = key;
        bus.MODE_REQ = mode;
        step();

        tr    = WS + resp_at;
        e_ok  = (kind == 1);
        e_err = (kind >= 2);
        e_to  = (kind == 0);
        fin   = (kind == 0) ? WS + T : tr + 1;
        last  = (abort_at >= 0) ? abort_at + 1 : fin + 1;

        for (int t = 0; t <= last; t++) begin
            cur_t = t;
            if (abort_at >= 0 && t == abort_at + 1) begin
                chk("abort_press", 32'(bus.PRESS),      32'h1);
                chk("abort_enter", 32'(bus.ENTER),      32'h1);
                chk("abort_busy",  32'(bus.BUSY),       32'h0);
                chk("abort_done",  32'(bus.DONE),       32'h0);
                chk("abort_ok",    32'(bus.RESULT_OK),  32'h0);
                chk("abort_err",   32'(bus.RESULT_ERR), 32'h0);
                chk("abort_to",    32'(bus.TIMEOUT),    32'h0);
                chk("abort_mode",  32'(bus.MODE),       32'(mode));
            end else begin
                d       = (t < N * L) ? t / L : N - 1;
                e_code  = 4'((key >> (4 * (N - 1 - d))) & 'hF);
                e_press = !(t < N * L && (t % L) >= 1 && (t % L) <= P);
                e_enter = !(t >= N * L && t < N * L + P);
                chk("code",  32'(bus.CODE),       32'(e_code));
                chk("press", 32'(bus.PRESS),      32'(e_press));
                chk("enter", 32'(bus.ENTER),      32'(e_enter));
                chk("mode",  32'(bus.MODE),       32'(mode));
                chk("busy",  32'(bus.BUSY),       32'(t <= fin));
                chk("done",  32'(bus.DONE),       32'(t == fin));
                chk("ok",    32'(bus.RESULT_OK),  32'(t >= fin && e_ok));
                chk("err",   32'(bus.RESULT_ERR), 32'(t >= fin && e_err));
                chk("to",    32'(bus.TIMEOUT),    32'(t >= fin && e_to));
            end
            if (t == last) break;
            bus.START    = junk && (t + 1 < WS);
            bus.KEY_WORD = '1;
            bus.MODE_REQ = ~mode;
            bus.ABORT    = (t == abort_at);
            if (abort_at < 0 && kind != 0 && t >= tr && t <= fin) begin
                bus.OPEN  = kind[0];
                bus.ERROR = kind[1];
            end else begin
                bus.OPEN  = 1'b0;
                bus.ERROR = 1'b0;
            end
            step();
        end
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.OPEN  = 1'b0;
        bus.ERROR = 1'b0;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        cur_t        = 0;
        RESET        = 1'b1;
        bus.START    = 1'b0;
        bus.ABORT    = 1'b0;
        bus.KEY_WORD = '0;
        bus.MODE_REQ = 1'b0;
        bus.OPEN     = 1'b0;
        bus.ERROR    = 1'b0;
        #12;
        chk_reset_vals("rst");
        RESET = 1'b0;
        step();
        chk_reset_vals("idle");

        // Basic send, OPEN 5 cycles after ENTER rises.
        run_seq(16'h1234, 1'b1, 1, 5, -1, 1'b0);
        // ERROR and OPEN together: ERROR wins.
        run_seq(16'h9999, 1'b0, 3, 3, -1, 1'b0);
        // No response: timeout.
        run_seq(16'hA5C3, 1'b1, 0, 0, -1, 1'b0);
        // Response on the last allowed cycle still beats the timeout.
        run_seq(16'h0F1E, 1'b0, 1, T - 1, -1, 1'b0);
        // ABORT during PRESS_LO of digit 2.
        run_seq(16'h5678, 1'b1, 1, 2, 2 * L + 2, 1'b0);
        // START held with KEY_WORD=FFFF while busy is ignored.
        run_seq(16'h4321, 1'b0, 2, 1, -1, 1'b1);

        // Reset pulse during ENTER_LO acts without a clock edge.
        bus.START    = 1'b1;
        bus.KEY_WORD = 16'h2468;
        bus.MODE_REQ = 1'b1;
        step();
        bus.START = 1'b0;
        for (int t = 0; t < N * L + 1; t++) step();
        cur_t = N * L + 1;
        chk("pre_rst_enter", 32'(bus.ENTER), 32'h0);
        #2;
        RESET = 1'b1;
        #1;
        chk_reset_vals("midrst");
        #3;
        RESET = 1'b0;
        step();
        chk_reset_vals("postrst");

        // Randomized sequences.
        for (int i = 0; i < 12; i++) begin
            logic [15:0] key;
            int kind, ra, ab;
            key  = 16'($urandom);
            kind = $urandom_range(0, 3);
            ra   = $urandom_range(0, T - 1);
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WS + 4)) : -1;
            run_seq(key, 1'($urandom_range(0, 1)), kind, ra, ab, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
